clk_div_monitor: RTL

- Receive-side companion to the team's clock divider: samples a divided clock (clk_div_in) in the clk_in domain and measures its period and high time in clk_in cycles.
- Compares each period against the expected divide ratio and reports lock, mismatch and loss-of-clock (timeout).
- Sits next to every divider instance as a built-in checker and bring-up monitor; status outputs feed the status/interrupt registers.

---
 rtl/clk_div_monitor_if.sv | 35 +++
 rtl/clk_div_monitor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor_if.sv
// Measurement bus between a clock-divider monitor and its consumer.
// The monitor side (master) receives the divided clock and drives the
// measurement and status signals; the slave side supplies the divided
// clock and reads the results.
interface clk_div_monitor_if #(
  parameter int W = 8
);
  logic         clk_div_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         meas_valid;
  logic         locked;
  logic         mismatch;
  logic         timeout;

  modport master (
    input  clk_div_in,
    output period,
    output high_time,
    output meas_valid,
    output locked,
    output mismatch,
    output timeout
  );

  modport slave (
    output clk_div_in,
    input  period,
    input  high_time,
    input  meas_valid,
    input  locked,
    input  mismatch,
    input  timeout
  );
endinterface

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: synchronizes clk_div_in into the clk_in domain,
// measures the period and high time of every full cycle of it, checks the
// period against EXP_N and reports lock, mismatch and loss-of-clock.
module clk_div_monitor #(
  parameter int EXP_N    = 5,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 64,
  parameter int W        = 8
) (
  input logic               clk_in,
  input logic               rst_n,
  clk_div_monitor_if.master bus
);

  localparam logic [W-1:0] EXP_V  = W'(EXP_N);
  localparam logic [W-1:0] LOCK_V = W'(LOCK_CNT);
  localparam logic [W-1:0] TMO_V  = W'(TIMEOUT);
  localparam logic [W-1:0] ONE_V  = W'(1);

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    RUN,
    STALL
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic         stall_go;

  logic         q1;
  logic         q2;
  logic         prev;
  logic [1:0]   settle;
  logic         rise;

  logic [W-1:0] per_cnt;
  logic [W-1:0] hi_cnt;
  logic [W-1:0] match_cnt;

  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         meas_valid;
  logic         mismatch;
  logic         locked;
  logic         timeout;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v,
                                           input logic [W-1:0] lim);
    return (v >= lim) ? v : v + ONE_V;
  endfunction

  // Two-flop synchronizer plus edge-history flop. settle marks when q2 has
  // been loaded from the real input after reset, so the cleared q2 is not
  // mistaken for a low phase of the input.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      q1     <= 1'b0;
      q2     <= 1'b0;
      prev   <= 1'b0;
      settle <= 2'b00;
    end else begin
      q1     <= bus.clk_div_in;
      q2     <= q1;
      prev   <= q2;
      settle <= {settle[0], 1'b1};
    end
  end

  assign rise = q2 & ~prev;

  // State register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_LOW;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; stall_go flags the cycle a running period overruns.
  always_comb begin
    state_nxt = state;
    stall_go  = 1'b0;
    case (state)
      WAIT_LOW: begin
        if (settle[1] && !q2) begin
          state_nxt = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!rise && (per_cnt == TMO_V)) begin
          state_nxt = STALL;
          stall_go  = 1'b1;
        end
      end
      STALL: begin
        if (rise) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = WAIT_LOW;
      end
    endcase
  end

  // Period and high-time counters; the rise sample itself counts as cycle 1.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else begin
      case (state)
        WAIT_RISE, STALL: begin
          if (rise) begin
            per_cnt <= ONE_V;
            hi_cnt  <= ONE_V;
          end
        end
        RUN: begin
          if (rise) begin
            per_cnt <= ONE_V;
            hi_cnt  <= ONE_V;
          end else begin
            per_cnt <= sat_inc(per_cnt, TMO_V);
            if (q2) begin
              hi_cnt <= sat_inc(hi_cnt, TMO_V);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Capture, period check, lock tracking and loss-of-clock flag.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      mismatch   <= 1'b0;
      match_cnt  <= '0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      mismatch   <= 1'b0;
      if ((state == RUN) && rise) begin
        period     <= per_cnt;
        high_time  <= hi_cnt;
        meas_valid <= 1'b1;
        if (per_cnt == EXP_V) begin
          match_cnt <= sat_inc(match_cnt, LOCK_V);
        end else begin
          mismatch  <= 1'b1;
          match_cnt <= '0;
        end
      end
      if (stall_go) begin
        timeout   <= 1'b1;
        match_cnt <= '0;
      end
      if ((state == STALL) && rise) begin
        timeout <= 1'b0;
      end
      locked <= (match_cnt == LOCK_V) && (state_nxt != STALL);
    end
  end

  assign bus.period     = period;
  assign bus.high_time  = high_time;
  assign bus.meas_valid = meas_valid;
  assign bus.mismatch   = mismatch;
  assign bus.locked     = locked;
  assign bus.timeout    = timeout;

endmodule
